// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot ROM loader (rom_loader, rom_word_packer).
package rom_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);
  localparam int WORD_W     = 8 * WORD_BYTES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/rom_word_packer.sv
// Little-endian byte-to-word packing register with synchronous clear, lane insert and fill flag.
module rom_word_packer
  import rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              fill_o
);

  logic [WORD_W-1:0] word_d, word_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    word_d = word_q;
    if (clr_i) begin
      word_d = '0;
    end else if (wr_i) begin
      word_d[8*lane_i +: 8] = byte_i;
    end
  end

  // NOTE: state registers use non-blocking assignments and the asynchronous active-low reset in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;
  assign fill_o = wr_i && (lane_i == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/rom_loader.sv
// Boot loader: streams ROM bytes into 32-bit little-endian words and writes them to memory.
// Optional byte checksum is built only when ROM_LOADER_CHECKSUM_EN is defined.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned MAX_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte,
  input  logic        rom_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        boot_done,
  output logic        error,
  output logic [7:0]  checksum
);

  localparam logic [31:0] GUARD_LAST = 32'(MAX_BYTES - 1);

  state_e      state_d, state_q;
  logic [31:0] addr_d, addr_q;
  logic [31:0] word_idx_d, word_idx_q;
  logic        last_d, last_q;
  logic        error_d, error_q;

  logic        load_start;
  logic        guard_hit;
  logic        pk_clr, pk_wr, pk_fill;
  logic [WORD_W-1:0] pk_word;

  assign load_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign guard_hit  = (addr_q == GUARD_LAST);

  rom_word_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (pk_clr),
    .wr_i   (pk_wr),
    .lane_i (addr_q[LANE_W-1:0]),
    .byte_i (rom_byte),
    .word_o (pk_word),
    .fill_o (pk_fill)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_idx_d = word_idx_q;
    last_d     = last_q;
    error_d    = error_q;
    pk_clr     = 1'b0;
    pk_wr      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          pk_clr     = 1'b1;
          addr_d     = '0;
          word_idx_d = '0;
          last_d     = 1'b0;
          error_d    = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        pk_wr  = 1'b1;
        addr_d = addr_q + 32'd1;
        if (rom_done || guard_hit) begin
          last_d = 1'b1;
        end
        // The guard only flags an error when the image did not end on the same byte.
        if (guard_hit && !rom_done) begin
          error_d = 1'b1;
        end
        if (pk_fill || rom_done || guard_hit) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          word_idx_d = word_idx_q + 32'd1;
          pk_clr     = 1'b1;
          state_d    = last_q ? S_DONE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_idx_q <= '0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_idx_q <= word_idx_d;
      last_q     <= last_d;
      error_q    <= error_d;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_d, sum_q;

  always_comb begin
    sum_d = sum_q;
    if (load_start) begin
      sum_d = '0;
    end else if (pk_wr) begin
      sum_d = sum_q + rom_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'd0;
`endif

  assign rom_address = addr_q;
  assign mem_addr    = MEM_BASE + {word_idx_q[29:0], 2'b00};
  assign mem_wdata   = pk_word;
  assign mem_we      = (state_q == S_WRITE);
  assign busy        = (state_q == S_FETCH) || (state_q == S_WRITE);
  assign boot_done   = (state_q == S_DONE);
  assign error       = error_q;

endmodule
